// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: grants the memory bus to the icache or dcache for whole line transactions
module cache_mem_arbiter #(
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = $clog2(BURST_LEN)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_mem_req,
  input  logic [31:0] i_mem_addr,
  output logic [31:0] i_mem_rdata,
  output logic        i_mem_addr_ok,
  output logic        i_mem_data_ok,
  input  logic        d_mem_req,
  input  logic        d_mem_wen,
  input  logic [31:0] d_mem_addr,
  input  logic [31:0] d_mem_wdata,
  input  logic        d_wlast,
  input  logic        d_awvalid,
  output logic [31:0] d_mem_rdata,
  output logic        d_mem_addr_ok,
  output logic        d_mem_data_ok,
  output logic        d_wb_ok,
  output logic        m_req,
  output logic        m_wen,
  output logic        m_wlast,
  output logic        m_awvalid,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic        m_wb_ok,
  output logic [1:0]  grant
);
  typedef enum logic [1:0] {IDLE, I_RD, D_RD, D_WR} state_e;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_d_q, last_d_d;
  logic             own_i, own_d, pick_d;
  assign own_i  = state_q == I_RD;
  assign own_d  = (state_q == D_RD) || (state_q == D_WR);
  assign pick_d = d_mem_req && (!i_mem_req || !last_d_q);
  // State, read beat counter and last owner (1 = dcache) registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_d_q <= last_d_d;
    end
  end
  // Arbitration in IDLE, completion by beat count for reads or wb_ok for writebacks
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d_d = last_d_q;
    case (state_q)
      IDLE: begin
        if (pick_d) state_d = d_mem_wen ? D_WR : D_RD;
        else if (i_mem_req) state_d = I_RD;
      end
      I_RD, D_RD: begin
        if (m_data_ok) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
            state_d  = IDLE;
            cnt_d    = '0;
            last_d_d = state_q == D_RD;
          end
        end
      end
      D_WR: begin
        if (m_wb_ok) begin
          state_d  = IDLE;
          last_d_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // Route the owner's request to the bus and bus responses back to the owner only
  always_comb begin
    m_req         = own_i ? i_mem_req : own_d && d_mem_req;
    m_wen         = own_d && d_mem_wen;
    m_wlast       = own_d && d_wlast;
    m_awvalid     = own_d && d_awvalid;
    m_addr        = own_i ? i_mem_addr : own_d ? d_mem_addr : 32'd0;
    m_wdata       = own_d ? d_mem_wdata : 32'd0;
    i_mem_addr_ok = own_i && m_addr_ok;
    i_mem_data_ok = own_i && m_data_ok;
    d_mem_addr_ok = own_d && m_addr_ok;
    d_mem_data_ok = own_d && m_data_ok;
    d_wb_ok       = (state_q == D_WR) && m_wb_ok;
    grant         = {own_d, own_i};
    i_mem_rdata   = m_rdata;
    d_mem_rdata   = m_rdata;
  end
endmodule
